// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard control with load-use stall, branch flush, memory-wait freeze,
// stall counting and a sticky memory-timeout error.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             rs1_sel,
  input  logic [4:0]             rs2_sel,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic                   id_valid,
  input  logic [4:0]             id_rd_sel,
  input  logic                   id_reg_wr_en,
  input  logic [2:0]             id_reg_wr_mux_sel,
  input  logic                   id_dmem_wr_en,
  input  logic                   ex_branch_taken,
  input  logic                   dmem_busy,
  output logic [4:0]             rd_sel_id_ex,
  output logic                   reg_wr_en_id_ex,
  output logic [2:0]             reg_wr_mux_sel_id_ex,
  output logic                   dmem_wr_en_id_ex,
  output logic [4:0]             rd_sel_ex_mem,
  output logic                   reg_wr_en_ex_mem,
  output logic [2:0]             reg_wr_mux_sel_ex_mem,
  output logic [4:0]             rd_sel_mem_wb,
  output logic                   reg_wr_en_mem_wb,
  output logic [2:0]             reg_wr_mux_sel_mem_wb,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   if_id_flush,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   mem_timeout
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [TW-1:0] T_MAX = TW'(MEM_TIMEOUT);
  state_t state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_inc;
  logic is_load, load_use, bubble_id;
  assign is_load = (reg_wr_mux_sel_id_ex != 3'd0) && (reg_wr_mux_sel_id_ex <= 3'd5);
  assign load_use = id_valid & reg_wr_en_id_ex & is_load & (rd_sel_id_ex != 5'd0) &
                    ((rs1_used & (rs1_sel == rd_sel_id_ex)) | (rs2_used & (rs2_sel == rd_sel_id_ex)));
  assign bubble_id = ex_branch_taken | load_use | !id_valid;
  assign tcnt_inc = tcnt + TW'(1);
  always_comb begin
    state_nxt = dmem_busy ? MEM_WAIT : RUN;
    pc_stall = rst_n & (dmem_busy | (!ex_branch_taken & load_use));
    if_id_stall = pc_stall;
    if_id_flush = rst_n & !dmem_busy & ex_branch_taken;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      tcnt <= '0;
      mem_timeout <= 1'b0;
      stall_cnt <= '0;
      rd_sel_id_ex <= '0;
      reg_wr_en_id_ex <= 1'b0;
      reg_wr_mux_sel_id_ex <= '0;
      dmem_wr_en_id_ex <= 1'b0;
      rd_sel_ex_mem <= '0;
      reg_wr_en_ex_mem <= 1'b0;
      reg_wr_mux_sel_ex_mem <= '0;
      rd_sel_mem_wb <= '0;
      reg_wr_en_mem_wb <= 1'b0;
      reg_wr_mux_sel_mem_wb <= '0;
    end else begin
      state <= state_nxt;
      if (pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (state == MEM_WAIT) begin
        tcnt <= (tcnt_inc >= T_MAX) ? T_MAX : tcnt_inc;
        if (tcnt_inc >= T_MAX) mem_timeout <= 1'b1;
      end else begin
        tcnt <= '0;
      end
      // a busy memory freezes every stage; otherwise the pipe shifts
      if (!dmem_busy) begin
        rd_sel_id_ex <= bubble_id ? 5'd0 : id_rd_sel;
        reg_wr_en_id_ex <= bubble_id ? 1'b0 : id_reg_wr_en;
        reg_wr_mux_sel_id_ex <= bubble_id ? 3'd0 : id_reg_wr_mux_sel;
        dmem_wr_en_id_ex <= bubble_id ? 1'b0 : id_dmem_wr_en;
        rd_sel_ex_mem <= rd_sel_id_ex;
        reg_wr_en_ex_mem <= reg_wr_en_id_ex;
        reg_wr_mux_sel_ex_mem <= reg_wr_mux_sel_id_ex;
        rd_sel_mem_wb <= rd_sel_ex_mem;
        reg_wr_en_mem_wb <= reg_wr_en_ex_mem;
        reg_wr_mux_sel_mem_wb <= reg_wr_mux_sel_ex_mem;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl with a small stall counter and short timeout.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_sel, rs2_sel, id_rd_sel;
  logic rs1_used, rs2_used, id_valid, id_reg_wr_en, id_dmem_wr_en, ex_branch_taken, dmem_busy;
  logic [2:0] id_reg_wr_mux_sel;
  logic [4:0] rd_sel_id_ex, rd_sel_ex_mem, rd_sel_mem_wb;
  logic reg_wr_en_id_ex, dmem_wr_en_id_ex, reg_wr_en_ex_mem, reg_wr_en_mem_wb;
  logic [2:0] reg_wr_mux_sel_id_ex, reg_wr_mux_sel_ex_mem, reg_wr_mux_sel_mem_wb;
  logic pc_stall, if_id_stall, if_id_flush, mem_timeout;
  logic [3:0] stall_cnt;
  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.STALL_CNT_W(4), .MEM_TIMEOUT(2)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .id_valid(id_valid), .id_rd_sel(id_rd_sel),
    .id_reg_wr_en(id_reg_wr_en), .id_reg_wr_mux_sel(id_reg_wr_mux_sel), .id_dmem_wr_en(id_dmem_wr_en),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .rd_sel_id_ex(rd_sel_id_ex), .reg_wr_en_id_ex(reg_wr_en_id_ex),
    .reg_wr_mux_sel_id_ex(reg_wr_mux_sel_id_ex), .dmem_wr_en_id_ex(dmem_wr_en_id_ex),
    .rd_sel_ex_mem(rd_sel_ex_mem), .reg_wr_en_ex_mem(reg_wr_en_ex_mem),
    .reg_wr_mux_sel_ex_mem(reg_wr_mux_sel_ex_mem), .rd_sel_mem_wb(rd_sel_mem_wb),
    .reg_wr_en_mem_wb(reg_wr_en_mem_wb), .reg_wr_mux_sel_mem_wb(reg_wr_mux_sel_mem_wb),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic id_in(input logic v, input logic [4:0] rd, input logic we, input logic [2:0] mux,
                       input logic dw, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2);
    id_valid = v; id_rd_sel = rd; id_reg_wr_en = we; id_reg_wr_mux_sel = mux; id_dmem_wr_en = dw;
    rs1_sel = r1; rs1_used = u1; rs2_sel = r2; rs2_used = u2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubbles(input string tag);
    check({tag, " pipe rd"}, {rd_sel_id_ex, rd_sel_ex_mem, rd_sel_mem_wb}, 15'd0);
    check({tag, " pipe ctl"}, {reg_wr_en_id_ex, reg_wr_mux_sel_id_ex, dmem_wr_en_id_ex, reg_wr_en_ex_mem,
          reg_wr_mux_sel_ex_mem, reg_wr_en_mem_wb, reg_wr_mux_sel_mem_wb}, 14'd0);
    check({tag, " cnt/timeout"}, {stall_cnt, mem_timeout}, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0; dmem_busy = 1'b1; ex_branch_taken = 1'b1;
    id_in(1, 5'd3, 1, 3'd1, 0, 5'd3, 1, 5'd0, 0);
    check("reset comb outs", {pc_stall, if_id_stall, if_id_flush}, 3'b000);
    tick();
    check_bubbles("reset");
    rst_n = 1'b1; dmem_busy = 1'b0; ex_branch_taken = 1'b0;
    // load x5 then a consumer of x5
    id_in(1, 5'd5, 1, 3'd1, 0, 5'd0, 0, 5'd0, 0);
    tick();
    check("load in id_ex", {rd_sel_id_ex, reg_wr_en_id_ex, reg_wr_mux_sel_id_ex}, {5'd5, 1'b1, 3'd1});
    id_in(1, 5'd6, 1, 3'd0, 0, 5'd5, 1, 5'd0, 0);
    check("load_use stall", {pc_stall, if_id_stall, if_id_flush}, 3'b110);
    tick();
    check("stall bubble id_ex", {rd_sel_id_ex, reg_wr_en_id_ex}, {5'd0, 1'b0});
    check("load advanced ex_mem", {rd_sel_ex_mem, reg_wr_mux_sel_ex_mem}, {5'd5, 3'd1});
    check("stall_cnt 1", stall_cnt, 4'd1);
    check("single stall cycle", pc_stall, 1'b0);
    tick();
    check("consumer issued", {rd_sel_id_ex, reg_wr_mux_sel_id_ex, rd_sel_mem_wb}, {5'd6, 3'd0, 5'd5});
    // ALU rd=6 in id_ex, consumer of x6: no stall; then load to x0
    id_in(1, 5'd0, 1, 3'd2, 0, 5'd6, 1, 5'd0, 0);
    check("alu no stall", pc_stall, 1'b0);
    tick();
    id_in(1, 5'd5, 1, 3'd0, 0, 5'd0, 1, 5'd0, 1);
    check("x0 no stall", pc_stall, 1'b0);
    tick();
    id_in(1, 5'd7, 1, 3'd3, 0, 5'd5, 1, 5'd0, 0);
    check("alu x5 no stall", pc_stall, 1'b0);
    tick();
    // store reading rs2 = load destination
    id_in(1, 5'd0, 0, 3'd0, 1, 5'd1, 1, 5'd7, 1);
    check("store rs2 stall", pc_stall, 1'b1);
    tick();
    check("store stall cnt", {stall_cnt, rd_sel_id_ex}, {4'd2, 5'd0});
    check("store after stall", pc_stall, 1'b0);
    tick();
    check("store issued", {dmem_wr_en_id_ex, reg_wr_en_id_ex}, 2'b10);
    // load_use and branch together: branch wins
    id_in(1, 5'd8, 1, 3'd5, 0, 5'd0, 0, 5'd0, 0);
    tick();
    id_in(1, 5'd9, 1, 3'd0, 0, 5'd0, 0, 5'd8, 1);
    ex_branch_taken = 1'b1; #1;
    check("branch over load_use", {pc_stall, if_id_stall, if_id_flush}, 3'b001);
    tick();
    ex_branch_taken = 1'b0;
    check("branch bubble", {rd_sel_id_ex, rd_sel_ex_mem, stall_cnt}, {5'd0, 5'd8, 4'd2});
    // fill pipe then freeze for 3 busy cycles
    id_in(1, 5'd10, 1, 3'd0, 0, 5'd0, 0, 5'd0, 0);
    tick();
    id_in(1, 5'd11, 1, 3'd0, 0, 5'd0, 0, 5'd0, 0);
    tick();
    id_in(1, 5'd12, 1, 3'd0, 0, 5'd0, 0, 5'd0, 0);
    dmem_busy = 1'b1; #1;
    check("busy stall", {pc_stall, if_id_stall, if_id_flush}, 3'b110);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin ex_branch_taken = 1'b1; #1; check("busy ignores branch", if_id_flush, 1'b0); end
      tick();
      ex_branch_taken = 1'b0;
      check($sformatf("frozen %0d", i), {rd_sel_id_ex, rd_sel_ex_mem, rd_sel_mem_wb}, {5'd11, 5'd10, 5'd0});
      if (i == 1) check("no timeout yet", mem_timeout, 1'b0);
    end
    check("busy cnt", {stall_cnt, mem_timeout}, {4'd5, 1'b1});
    dmem_busy = 1'b0; #1;
    check("resume no stall", pc_stall, 1'b0);
    tick();
    check("resumed", {rd_sel_id_ex, rd_sel_ex_mem, rd_sel_mem_wb}, {5'd12, 5'd11, 5'd10});
    check("timeout sticky", {mem_timeout, stall_cnt}, {1'b1, 4'd5});
    // saturate the stall counter
    dmem_busy = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("stall_cnt saturated", stall_cnt, 4'hf);
    // reset in the middle of a memory wait
    rst_n = 1'b0; ex_branch_taken = 1'b1; #1;
    check("reset comb in wait", {pc_stall, if_id_stall, if_id_flush}, 3'b000);
    tick();
    check_bubbles("reset in wait");
    rst_n = 1'b1; dmem_busy = 1'b0; ex_branch_taken = 1'b0;
    id_in(0, 5'd9, 1, 3'd1, 1, 5'd0, 0, 5'd0, 0);
    tick();
    check("invalid bubble", {rd_sel_id_ex, reg_wr_en_id_ex, dmem_wr_en_id_ex}, 7'd0);
    dmem_busy = 1'b1;
    tick();
    dmem_busy = 1'b0;
    tick();
    check("short wait no timeout", {mem_timeout, stall_cnt}, {1'b0, 4'd1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, stall-counter width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, max consecutive MEM_WAIT cycles before error.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have ports rs1_sel, rs2_sel  in  5 each  ID-stage source registers.
REQ-006 SHALL have ports rs1_used, rs2_used  in  1 each  ID instruction reads rs1/rs2.
REQ-007 SHALL have ports id_valid  in  1; id_rd_sel  in  5; id_reg_wr_en  in  1; id_reg_wr_mux_sel  in  3; id_dmem_wr_en  in  1  ID-stage control.
REQ-008 SHALL have port ex_branch_taken  in  1  redirect resolved in EX.
REQ-009 SHALL have port dmem_busy  in  1  data memory not ready; freeze pipeline.
REQ-010 SHALL have outputs rd_sel_id_ex (5), reg_wr_en_id_ex (1), reg_wr_mux_sel_id_ex (3), dmem_wr_en_id_ex (1)  ID/EX control register.
REQ-011 SHALL have outputs rd_sel_ex_mem (5), reg_wr_en_ex_mem (1), reg_wr_mux_sel_ex_mem (3)  EX/MEM control register.
REQ-012 SHALL have outputs rd_sel_mem_wb (5), reg_wr_en_mem_wb (1), reg_wr_mux_sel_mem_wb (3)  MEM/WB control register.
REQ-013 SHALL have outputs pc_stall, if_id_stall, if_id_flush  (1 each, combinational)  front-end control.
REQ-014 SHALL have outputs stall_cnt  STALL_CNT_W  total stall cycles; mem_timeout  1  sticky error.

Function
REQ-015 SHALL classify a load as reg_wr_mux_sel in 1..5; ALU write as 0.
REQ-016 SHALL define load_use = reg_wr_en_id_ex & load(reg_wr_mux_sel_id_ex) & rd_sel_id_ex!=0 & ((rs1_used & rs1_sel==rd_sel_id_ex) | (rs2_used & rs2_sel==rd_sel_id_ex)) & id_valid.
REQ-017 SHALL never flag a hazard on register x0.
REQ-018 SHALL define bubble as rd_sel=0, reg_wr_en=0, reg_wr_mux_sel=0, dmem_wr_en=0.
REQ-019 SHALL use FSM states RUN and MEM_WAIT; RUN->MEM_WAIT when dmem_busy=1; MEM_WAIT->RUN on the first cycle dmem_busy=0.
REQ-020 SHALL, while dmem_busy=1 (any state), hold all three pipeline registers, assert pc_stall=if_id_stall=1, if_id_flush=0, ignore ex_branch_taken and load_use.
REQ-021 SHALL, with dmem_busy=0 and ex_branch_taken=1, load bubble into ID/EX, assert if_id_flush=1, pc_stall=if_id_stall=0, advance EX/MEM and MEM/WB; branch overrides load_use.
REQ-022 SHALL, with dmem_busy=0, ex_branch_taken=0, load_use=1, load bubble into ID/EX, assert pc_stall=if_id_stall=1, advance EX/MEM and MEM/WB; exactly one stall cycle per load-use pair.
REQ-023 SHALL otherwise advance: ID/EX<=ID inputs (bubble if id_valid=0), EX/MEM<=ID/EX, MEM/WB<=EX/MEM; all stall/flush outputs 0.
REQ-024 SHALL increment stall_cnt by 1 each cycle pc_stall=1, saturating at all-ones.
REQ-025 SHALL count consecutive MEM_WAIT cycles; on reaching MEM_TIMEOUT, set mem_timeout=1 and hold until reset; counter clears on leaving MEM_WAIT.
REQ-026 SHALL forward store hazards only via register outputs; a store after load to same rs2 is a load_use stall.

Reset
REQ-027 SHALL, when rst_n=0 at a rising clk, set all three pipeline registers to bubble, FSM=RUN, stall_cnt=0, timeout counter=0, mem_timeout=0.
REQ-028 SHALL give reset priority over dmem_busy, branch and load_use, including mid-MEM_WAIT.
REQ-029 SHALL drive pc_stall, if_id_stall, if_id_flush=0 while rst_n=0.

Verification
REQ-030 SHALL cover: load x5 in ID/EX (mux_sel=1), ID rs1=5 used -> one cycle pc_stall=1, ID/EX bubble, next cycle rd_sel_ex_mem=5, stall_cnt=1.
REQ-031 SHALL cover: load rd=0, ID rs1=0 used -> no stall; ALU rd=5 in ID/EX, rs1=5 -> no stall.
REQ-032 SHALL cover: load_use and ex_branch_taken same cycle -> if_id_flush=1, pc_stall=0, ID/EX bubble.
REQ-033 SHALL cover: dmem_busy high 3 cycles -> registers frozen 3 cycles, stall_cnt+=3, resume on 4th; with MEM_TIMEOUT=2 -> mem_timeout=1 sticky.
REQ-034 SHALL cover: rst_n=0 during MEM_WAIT -> next cycle all outputs bubble/0, FSM RUN.
REQ-035 SHALL cover: stall_cnt at all-ones plus further stall -> remains all-ones.
